// File: rtl/picovid_pkg.sv
// Shared types and constants for the Pico video write-snoop streamer.
package picovid_pkg;

  // Frame sequencer states: one state per byte currently presented on DOUT.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_A2   = 3'd2,
    ST_A1   = 3'd3,
    ST_A0   = 3'd4,
    ST_D1   = 3'd5,
    ST_D0   = 3'd6,
    ST_END  = 3'd7
  } frame_state_t;

  // Header byte layout: {start, overflow, 4'b0000, upper lane, lower lane}.
  localparam int HDR_START_BIT = 7;
  localparam int HDR_OVF_BIT   = 6;
  localparam int HDR_UDS_BIT   = 1;
  localparam int HDR_LDS_BIT   = 0;

  // One queued write: byte address, data word, active-high lane flags.
  localparam int ENTRY_W = 42;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        uds;
    logic        lds;
  } entry_t;

  function automatic logic [7:0] make_header(input logic ovf, input logic uds, input logic lds);
    logic [7:0] h;
    h                = 8'h00;
    h[HDR_START_BIT] = 1'b1;
    h[HDR_OVF_BIT]   = ovf;
    h[HDR_UDS_BIT]   = uds;
    h[HDR_LDS_BIT]   = lds;
    return h;
  endfunction

endpackage

// File: rtl/picovid_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// Storage is not reset; only the pointers are.
module picovid_fifo #(
  parameter int WIDTH = 42,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // Pointer update; wraps naturally at 2**AW with the extra bit toggling.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Entry storage write.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/picovid_stream.sv
// Snoops 68000 writes into an address window, queues them and streams each
// as a byte-serial frame clocked out by the Pico's STROBE falling edges.
module picovid_stream
  import picovid_pkg::*;
#(
  parameter logic [23:0] ADDR_BASE   = 24'h078000,
  parameter logic [23:0] ADDR_MASK   = 24'hFF8000,
  parameter int          FIFO_AW     = 3,
  parameter int          SYNC_STAGES = 2,
  parameter int          SEND_HEADER = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic [15:0] D,
  input  logic        RW,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        DTACK,
  input  logic        STROBE,
  output logic [7:0]  DOUT,
  output logic        DOE,
  output logic        RTS_N,
  output logic        OVERFLOW
);

  logic [SYNC_STAGES-1:0] r_as_sync;
  logic [SYNC_STAGES-1:0] r_dtack_sync;
  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic                   r_stb_prev;
  logic                   r_armed;
  logic                   r_ovf;
  logic                   r_rts_n;
  logic                   r_doe;
  logic [7:0]             r_dout;
  frame_state_t           r_state;
  entry_t                 r_frame;

  logic                   w_as_s;
  logic                   w_dtack_s;
  logic                   w_stb_s;
  logic                   w_fall;
  logic                   w_hit;
  logic                   w_wr;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  logic                   w_load;
  logic                   w_hdr_emit;
  logic                   w_doe_nxt;
  logic [7:0]             w_dout_nxt;
  frame_state_t           w_state_nxt;
  entry_t                 w_wdata;
  entry_t                 w_head;

  assign w_as_s    = r_as_sync[SYNC_STAGES-1];
  assign w_dtack_s = r_dtack_sync[SYNC_STAGES-1];
  assign w_stb_s   = r_stb_sync[SYNC_STAGES-1];
  assign w_fall    = r_stb_prev & ~w_stb_s;

  assign w_hit   = (({A, 1'b0} & ADDR_MASK) == ADDR_BASE);
  assign w_wr    = w_hit & ~RW & ~w_as_s & ~w_dtack_s & (~UDS | ~LDS);
  // r_armed is re-armed only by AS_s high, so one bus cycle yields at most one push.
  assign w_push  = w_wr & r_armed;
  assign w_drop  = w_push & w_full & ~w_pop;

  assign w_wdata = '{addr: {A, 1'b0}, data: D, uds: ~UDS, lds: ~LDS};

  // Synchronisers for the asynchronous bus strobes and the Pico byte clock (idle high).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_as_sync    <= '1;
      r_dtack_sync <= '1;
      r_stb_sync   <= '1;
      r_stb_prev   <= 1'b1;
    end else begin
      r_as_sync    <= {r_as_sync[SYNC_STAGES-2:0], AS};
      r_dtack_sync <= {r_dtack_sync[SYNC_STAGES-2:0], DTACK};
      r_stb_sync   <= {r_stb_sync[SYNC_STAGES-2:0], STROBE};
      r_stb_prev   <= w_stb_s;
    end
  end

  // Capture arming: set between bus cycles, cleared by the push it allows.
  always_ff @(posedge CLK) begin
    if (RESET)       r_armed <= 1'b0;
    else if (w_as_s) r_armed <= 1'b1;
    else if (w_push) r_armed <= 1'b0;
  end

  picovid_fifo #(
    .WIDTH (ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky overflow: a drop wins over the clear from an emitted header.
  always_ff @(posedge CLK) begin
    if (RESET)           r_ovf <= 1'b0;
    else if (w_drop)     r_ovf <= 1'b1;
    else if (w_hdr_emit) r_ovf <= 1'b0;
  end

  // Frame sequencer state register and registered byte outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_doe   <= 1'b0;
      r_dout  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_doe   <= w_doe_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  // Frame register holds the popped entry so later pushes cannot disturb a frame in flight.
  always_ff @(posedge CLK) begin
    if (w_load) r_frame <= w_head;
  end

  // Next-state and byte selection; every transition is gated by a STROBE fall,
  // except END which just returns to IDLE after the closing strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_doe_nxt   = r_doe;
    w_dout_nxt  = r_dout;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_hdr_emit  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_doe_nxt = 1'b0;
        if (w_fall && !w_empty) begin
          w_pop     = 1'b1;
          w_load    = 1'b1;
          w_doe_nxt = 1'b1;
          if (SEND_HEADER != 0) begin
            w_state_nxt = ST_HDR;
            w_dout_nxt  = make_header(r_ovf, w_head.uds, w_head.lds);
            w_hdr_emit  = 1'b1;
          end else begin
            w_state_nxt = ST_A2;
            w_dout_nxt  = w_head.addr[23:16];
          end
        end
      end
      ST_HDR: if (w_fall) begin
        w_state_nxt = ST_A2;
        w_dout_nxt  = r_frame.addr[23:16];
      end
      ST_A2: if (w_fall) begin
        w_state_nxt = ST_A1;
        w_dout_nxt  = r_frame.addr[15:8];
      end
      ST_A1: if (w_fall) begin
        w_state_nxt = ST_A0;
        w_dout_nxt  = r_frame.addr[7:0];
      end
      ST_A0: if (w_fall) begin
        w_state_nxt = ST_D1;
        w_dout_nxt  = r_frame.data[15:8];
      end
      ST_D1: if (w_fall) begin
        w_state_nxt = ST_D0;
        w_dout_nxt  = r_frame.data[7:0];
      end
      ST_D0: if (w_fall) begin
        // Blank closing strobe: release the pins, DOUT keeps the last byte.
        w_state_nxt = ST_END;
        w_doe_nxt   = 1'b0;
      end
      ST_END: begin
        w_state_nxt = ST_IDLE;
        w_doe_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_doe_nxt   = 1'b0;
      end
    endcase
  end

  // Request-to-send, registered so the open-drain pin sees a clean level.
  always_ff @(posedge CLK) begin
    if (RESET) r_rts_n <= 1'b1;
    else       r_rts_n <= ~(~w_empty | (r_state != ST_IDLE));
  end

  assign DOUT     = r_dout;
  assign DOE      = r_doe;
  assign RTS_N    = r_rts_n;
  assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_picovid_stream.sv
// Bench for picovid_stream: vector table, multi-cycle corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_picovid_stream;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [23:1] A = '0;
  logic [15:0] D = '0;
  logic        RW = 1'b1;
  logic        AS = 1'b1;
  logic        UDS = 1'b1;
  logic        LDS = 1'b1;
  logic        DTACK = 1'b1;
  logic        STROBE = 1'b1;
  logic [7:0]  DOUT;
  logic        DOE;
  logic        RTS_N;
  logic        OVERFLOW;

  int n_cmp  = 0;
  int n_fail = 0;

  picovid_stream dut (
    .CLK(CLK), .RESET(RESET), .A(A), .D(D), .RW(RW), .AS(AS), .UDS(UDS), .LDS(LDS),
    .DTACK(DTACK), .STROBE(STROBE), .DOUT(DOUT), .DOE(DOE), .RTS_N(RTS_N), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic        uds_n;
    logic        lds_n;
    logic        rw;
    logic        push;
    logic [47:0] bytes;
  } vec_t;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic        uds;
    logic        lds;
  } ment_t;

  vec_t  vt [8];
  ment_t mq [$];
  logic  m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic [23:0] addr, input logic [15:0] data,
                           input logic uds_n, input logic lds_n, input logic rw);
    @(negedge CLK);
    A = addr[23:1]; D = data; RW = rw; UDS = uds_n; LDS = lds_n; AS = 1'b0;
    repeat (2) @(negedge CLK);
    DTACK = 1'b0;
    repeat (5) @(negedge CLK);
    AS = 1'b1; DTACK = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic strobe();
    @(negedge CLK);
    STROBE = 1'b0;
    repeat (5) @(negedge CLK);
    STROBE = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  // Clocks out the bytes of a frame from index 'first' plus the closing strobe.
  task automatic check_frame(input string nm, input logic [47:0] exp, input int first);
    for (int i = first; i < 6; i++) begin
      strobe();
      chk($sformatf("%s doe b%0d", nm, i), {31'b0, DOE}, 32'd1);
      chk($sformatf("%s dout b%0d", nm, i), {24'b0, DOUT}, {24'b0, exp[47-8*i -: 8]});
    end
    strobe();
    chk($sformatf("%s close doe", nm), {31'b0, DOE}, 32'd0);
  endtask

  function automatic logic [47:0] frame_bytes(input logic ovf, input logic uds, input logic lds,
                                              input logic [23:0] addr, input logic [15:0] data);
    return {1'b1, ovf, 4'b0000, uds, lds, addr, data};
  endfunction

  initial begin
    vt[0] = '{24'h078010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 48'h83_07_80_10_BE_EF};
    vt[1] = '{24'h078001, 16'h0042, 1'b1, 1'b0, 1'b0, 1'b1, 48'h81_07_80_00_00_42};
    vt[2] = '{24'h100000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0};
    vt[3] = '{24'h078020, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b0, 48'h0};
    vt[4] = '{24'h07FFFE, 16'hA55A, 1'b0, 1'b1, 1'b0, 1'b1, 48'h82_07_FF_FE_A5_5A};
    vt[5] = '{24'h080000, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0};
    vt[6] = '{24'h078100, 16'h2222, 1'b1, 1'b1, 1'b0, 1'b0, 48'h0};
    vt[7] = '{24'h077FFE, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0};

    // Reset state
    repeat (4) @(negedge CLK);
    chk("reset dout", {24'b0, DOUT}, 32'h0);
    chk("reset doe", {31'b0, DOE}, 32'd0);
    chk("reset rts_n", {31'b0, RTS_N}, 32'd1);
    chk("reset ovf", {31'b0, OVERFLOW}, 32'd0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    // Table of single transactions
    for (int v = 0; v < 8; v++) begin
      bus_cycle(vt[v].addr, vt[v].data, vt[v].uds_n, vt[v].lds_n, vt[v].rw);
      chk($sformatf("vec%0d rts_n", v), {31'b0, RTS_N}, {31'b0, ~vt[v].push});
      if (vt[v].push) begin
        check_frame($sformatf("vec%0d", v), vt[v].bytes, 0);
      end else begin
        strobe();
        chk($sformatf("vec%0d idle doe", v), {31'b0, DOE}, 32'd0);
      end
      chk($sformatf("vec%0d rts_n end", v), {31'b0, RTS_N}, 32'd1);
    end

    // Nine writes into a depth-8 queue: last one dropped
    for (int i = 0; i < 9; i++)
      bus_cycle(24'h078000 + 24'(2*i), 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
    chk("ovf set", {31'b0, OVERFLOW}, 32'd1);
    chk("ovf rts_n", {31'b0, RTS_N}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_frame($sformatf("ovf f%0d", i),
                  frame_bytes(i == 0, 1'b1, 1'b1, 24'h078000 + 24'(2*i), 16'h1000 + 16'(i)), 0);
      if (i == 0) chk("ovf cleared", {31'b0, OVERFLOW}, 32'd0);
    end
    chk("ovf drained rts_n", {31'b0, RTS_N}, 32'd1);

    // Push coinciding with a pop while full
    for (int i = 0; i < 8; i++)
      bus_cycle(24'h078100 + 24'(2*i), 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    A = 23'(24'h078200 >> 1); D = 16'hCAFE; RW = 1'b0; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
    repeat (4) @(negedge CLK);
    DTACK = 1'b0; STROBE = 1'b0;
    repeat (5) @(negedge CLK);
    chk("same-cycle doe", {31'b0, DOE}, 32'd1);
    chk("same-cycle hdr", {24'b0, DOUT}, 32'h83);
    chk("same-cycle ovf", {31'b0, OVERFLOW}, 32'd0);
    AS = 1'b1; DTACK = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1; STROBE = 1'b1;
    repeat (5) @(negedge CLK);
    check_frame("same-cycle f0", frame_bytes(1'b0, 1'b1, 1'b1, 24'h078100, 16'h2000), 1);
    for (int i = 1; i < 8; i++)
      check_frame($sformatf("same-cycle f%0d", i),
                  frame_bytes(1'b0, 1'b1, 1'b1, 24'h078100 + 24'(2*i), 16'h2000 + 16'(i)), 0);
    check_frame("same-cycle new", 48'h83_07_82_00_CA_FE, 0);
    chk("same-cycle ovf end", {31'b0, OVERFLOW}, 32'd0);
    chk("same-cycle rts_n end", {31'b0, RTS_N}, 32'd1);

    // Reset in the middle of a frame
    bus_cycle(24'h078040, 16'h4444, 1'b0, 1'b0, 1'b0);
    bus_cycle(24'h078042, 16'h5555, 1'b0, 1'b0, 1'b0);
    repeat (3) strobe();
    chk("midreset pre doe", {31'b0, DOE}, 32'd1);
    chk("midreset pre dout", {24'b0, DOUT}, 32'h80);
    @(negedge CLK) RESET = 1'b1;
    @(negedge CLK) RESET = 1'b0;
    chk("midreset doe", {31'b0, DOE}, 32'd0);
    chk("midreset rts_n", {31'b0, RTS_N}, 32'd1);
    chk("midreset dout", {24'b0, DOUT}, 32'h0);
    strobe();
    chk("midreset strobe doe", {31'b0, DOE}, 32'd0);
    chk("midreset empty rts_n", {31'b0, RTS_N}, 32'd1);

    // Randomized traffic against the queue model
    m_ovf = 1'b0;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [23:0] addr;
        logic [31:0] rnd;
        logic [15:0] data;
        logic        uds_n, lds_n, rw;
        rnd = $urandom;
        if ($urandom_range(0, 3) != 0) addr = 24'h078000 + 24'($urandom_range(0, 16383) * 2);
        else                           addr = rnd[23:0] & 24'hFFFFFE;
        data  = 16'($urandom);
        uds_n = 1'($urandom_range(0, 1));
        lds_n = 1'($urandom_range(0, 1));
        rw    = ($urandom_range(0, 5) == 0);
        bus_cycle(addr, data, uds_n, lds_n, rw);
        if (addr >= 24'h078000 && addr <= 24'h07FFFF && !rw && (!uds_n || !lds_n)) begin
          if (mq.size() < 8) mq.push_back('{addr, data, ~uds_n, ~lds_n});
          else               m_ovf = 1'b1;
        end
        chk($sformatf("rnd%0d ovf", it), {31'b0, OVERFLOW}, {31'b0, m_ovf});
        chk($sformatf("rnd%0d rts_n", it), {31'b0, RTS_N}, (mq.size() == 0) ? 32'd1 : 32'd0);
      end else if (mq.size() == 0) begin
        strobe();
        chk($sformatf("rnd%0d empty doe", it), {31'b0, DOE}, 32'd0);
      end else begin
        ment_t e;
        e = mq.pop_front();
        check_frame($sformatf("rnd%0d", it), frame_bytes(m_ovf, e.uds, e.lds, e.addr, e.data), 0);
        m_ovf = 1'b0;
        chk($sformatf("rnd%0d post ovf", it), {31'b0, OVERFLOW}, 32'd0);
        chk($sformatf("rnd%0d post rts_n", it), {31'b0, RTS_N}, (mq.size() == 0) ? 32'd1 : 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
